branch_predictor: RTL

- Parametrised branch target buffer (BTB) with 2-bit saturating-counter direction prediction for the 5-stage pipelined core.
- Sits beside the PC register in IF and predicts next PC each cycle. Branch/jump resolution in MEM trains it.
- Lets the pcIn mux select a predicted target in IF instead of always taking the fall-through address.
- A redirect and IF/ID + ID/EX flush happens only when a prediction was wrong.

---
 rtl/bp_pkg.sv | 16 +
 rtl/branch_predictor_if.sv | 33 +++
 rtl/sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit direction counter states
// and the values used on reset and on allocation.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET     = WNT;
    localparam ctr_e CTR_ALLOC_BR  = WT;
    localparam ctr_e CTR_ALLOC_JMP = ST;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, training and statistics signals between the core and the branch predictor.
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int STAT_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] lookup_pc;
    logic                  predict_hit;
    logic                  predict_taken;
    logic [ADDR_WIDTH-1:0] predict_target;

    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_jump;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    logic                  invalidate;

    logic [STAT_WIDTH-1:0] stat_lookups;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
               upd_mispredict, invalidate,
        input  predict_hit, predict_taken, predict_target, stat_lookups, stat_mispredicts
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
               upd_mispredict, invalidate,
        output predict_hit, predict_taken, predict_target, stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/sat_counter2.sv
// Combinational next value of a 2-bit saturating direction counter,
// with a force-to-strong-taken input for unconditional jumps.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e cnt_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic force_st_i,
    output ctr_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (force_st_i) begin
            cnt_o = ST;
        end else if (inc_i && (cnt_i != ST)) begin
            cnt_o = ctr_e'(cnt_i + 2'b01);
        end else if (dec_i && (cnt_i != SNT)) begin
            cnt_o = ctr_e'(cnt_i - 2'b01);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters: combinational
// next-PC prediction in IF, trained by resolved control flow from MEM.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 64,
    parameter int STAT_WIDTH = 16
) (
    input logic               clock,
    input logic               clear,
    branch_predictor_if.slave bus
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic                  valid_q  [ENTRIES];
    ctr_e                  ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

    logic [STAT_WIDTH-1:0] lookups_q, lookups_d;
    logic [STAT_WIDTH-1:0] mispredicts_q, mispredicts_d;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic                  lk_taken;

    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  eff_taken;
    logic                  wr_en;
    ctr_e                  ctr_rmw;
    ctr_e                  ctr_d;

    // Lookup reads only registered state, so a same-cycle update is seen next cycle.
    always_comb begin
        lk_idx   = bus.lookup_pc[INDEX_BITS-1:0];
        lk_tag   = bus.lookup_pc[ADDR_WIDTH-1:INDEX_BITS];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][1];
    end

    assign bus.predict_hit    = lk_hit;
    assign bus.predict_taken  = lk_taken;
    assign bus.predict_target = lk_taken ? target_q[lk_idx] : (bus.lookup_pc + PC_STEP);

    always_comb begin
        up_idx    = bus.upd_pc[INDEX_BITS-1:0];
        up_tag    = bus.upd_pc[ADDR_WIDTH-1:INDEX_BITS];
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        eff_taken = bus.upd_jump || bus.upd_taken;
        wr_en     = bus.upd_valid && !bus.invalidate && (up_hit || eff_taken);
    end

    sat_counter2 u_ctr (
        .cnt_i      (ctr_q[up_idx]),
        .inc_i      (eff_taken),
        .dec_i      (!eff_taken),
        .force_st_i (bus.upd_jump),
        .cnt_o      (ctr_rmw)
    );

    // A miss that allocates discards the old occupant's history entirely.
    always_comb begin
        ctr_d = ctr_rmw;
        if (!up_hit) begin
            ctr_d = bus.upd_jump ? CTR_ALLOC_JMP : CTR_ALLOC_BR;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (bus.invalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

    // Tags and targets are only meaningful behind a set valid bit, so they are never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[up_idx] <= up_tag;
            if (eff_taken) begin
                target_q[up_idx] <= bus.upd_target;
            end
        end
    end

    always_comb begin
        lookups_d     = lookups_q;
        mispredicts_d = mispredicts_q;
        if (bus.upd_valid && (lookups_q != STAT_MAX)) begin
            lookups_d = lookups_q + STAT_ONE;
        end
        if (bus.upd_valid && bus.upd_mispredict && (mispredicts_q != STAT_MAX)) begin
            mispredicts_d = mispredicts_q + STAT_ONE;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            lookups_q     <= lookups_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign bus.stat_lookups     = lookups_q;
    assign bus.stat_mispredicts = mispredicts_q;

endmodule
